phase_interp_sched: RTL
=======================

# phase_interp_sched

Round-robin scheduler that shares one phase-interpolation pipeline among `NREQ` requesters. It sits in front of the interpolator and:

- arbitrates requests and tags each issued operation with the requester index in the interpolator's pass-through field;
- limits in-flight operations with a credit counter;
- steers each returned result to the requester that issued it.

## Interface

Parameters:

- `NREQ`, 4: number of requesters (2..8).
- `PHASE_DW`, 15: phase width.
- `FBIT`, 8: fraction width.
- `USER_DW`, 4: per-request user tag, returned with the result.
- `MAX_OUT`, 4: maximum operations in flight (1..15).
- `IDW`, derived: `$clog2(NREQ)`.
- `PASS_DW`, derived: `IDW+USER_DW`.

Ports:

- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NREQ: request valid per requester.
- `req_ready`  out  NREQ: request accepted, one-hot or zero.
- `req_phase1`  in  NREQ*PHASE_DW: packed, requester i at `[i*PHASE_DW +: PHASE_DW]`.
- `req_phase2`  in  NREQ*PHASE_DW: packed, same layout.
- `req_frac`  in  NREQ*FBIT: packed fractions.
- `req_user`  in  NREQ*USER_DW: packed user tags.
- `ip_valid` / `ip_ready`  out / in  1: issue handshake to the interpolator.
- `ip_phase1`, `ip_phase2`  out  PHASE_DW: issued operands.
- `ip_frac`  out  FBIT: issued fraction.
- `ip_pass_data`  out  PASS_DW: `{user, id}`, id in the low IDW bits.
- `res_valid` / `res_ready`  in / out  1: result handshake from the interpolator.
- `res_phase`  in  PHASE_DW: result phase.
- `res_pass_data`  in  PASS_DW: returned `{user, id}`.
- `rsp_valid`  out  NREQ: one-hot result valid.
- `rsp_ready`  in  NREQ: per-requester result ready.
- `rsp_phase`  out  PHASE_DW: result phase, shared by all requesters.
- `rsp_user`  out  USER_DW: returned user tag, shared.
- `outstanding`  out  4: current in-flight count.
- `stat_sel`  in  IDW: statistics counter select.
- `stat_cnt`  out  16: selected statistics counter.

## Operation

- Issue register: a single holding register drives the `ip_*` outputs.
  - It can load when it is empty, or when `ip_valid && ip_ready` occurs in the same cycle.
  - Load also requires a credit: `outstanding < MAX_OUT`.
- Arbitration:
  - Round-robin search starting at `last_grant+1` mod NREQ; the first requester with `req_valid` set wins.
  - `req_ready[g]` is asserted combinationally in the load cycle for the winner only. `req_ready` must never be asserted while no load occurs.
  - `last_grant` updates only on a grant.
- Credits:
  - `outstanding` increments on load.
  - It decrements on `res_valid && res_ready`.
  - If a load and a return occur in the same cycle, the count is unchanged.
  - It never exceeds `MAX_OUT` and never underflows.
  - A return with `outstanding==0` is a protocol error; the count must stay at 0 (assertion in simulation).
- Return path:
  - Purely combinational, independent of the issue side.
  - `id = res_pass_data[IDW-1:0]`.
  - `rsp_valid = res_valid ? (1<<id) : 0`.
  - `res_ready = rsp_ready[id]`.
  - `rsp_phase = res_phase`; `rsp_user = res_pass_data[PASS_DW-1:IDW]`.
  - An id ≥ NREQ must drop the result: `res_ready=1`, no `rsp_valid`, credit still returned.
- Results from the interpolator arrive in issue order. This block adds no reordering.

## Timing

- Reset values:
  - `ip_valid`, `req_ready`, `rsp_valid`, `outstanding`, `stat_cnt` = 0.
  - `ip_*` data = 0.
  - `last_grant = NREQ-1`, so the first grant goes to requester 0.
- Reset mid-operation: in-flight credits are discarded and the counter restarts at 0. The interpolator must be reset in the same cycle.
- Latency: a request accepted in cycle N is presented on `ip_*` in cycle N+1.
- Throughput: back-to-back issue at 1 per cycle while `ip_ready=1` and credits are available.
- `ip_*` data and `ip_valid` must hold stable while `ip_valid && !ip_ready`.
- Return path latency is 0 cycles. Backpressure on `rsp_ready[id]` stalls the interpolator output directly.
- Fairness: under continuous demand from all requesters, each requester is granted exactly once every NREQ grants.

## Configuration

- `PHASE_SCHED_STATS_EN` defined: per-requester 16-bit counters.
  - A counter increments on each grant to its requester.
  - Counters saturate at 0xFFFF and clear on `rst`.
  - `stat_cnt` = counter[`stat_sel`], registered, with 1-cycle latency.
- `PHASE_SCHED_STATS_EN` undefined:
  - No counters are built.
  - `stat_cnt` is tied to 0.
  - `stat_sel` is ignored.

## Test plan

- All four requesters hold `req_valid` high; `ip_ready=1`; results return after 4 cycles with `rsp_ready` all ones -> grant order 0,1,2,3,0,1,…; `ip_pass_data` id field matches each grant; `outstanding` peaks at 4.
- `MAX_OUT=2`; `res_valid` held low -> exactly 2 loads, then `req_ready=0` and `outstanding=2`. One return then re-enables exactly one load.
- `ip_ready=0` for 5 cycles with a loaded request (phase1=0x1234, frac=0x80) -> `ip_*` stable for all 5 cycles; no `req_ready` pulses.
- Return with id=2, user=0xA, `rsp_ready[2]=0` for 3 cycles -> `rsp_valid=4'b0100` held and `res_ready=0`. The handshake completes when `rsp_ready[2]=1`; `rsp_user=0xA`.
- Load and return in the same cycle at `outstanding=3` -> the count stays 3. Asserting `rst` mid-stream -> all outputs return to their reset values on the next edge.
- With `PHASE_SCHED_STATS_EN`: 10 grants to requester 1 -> `stat_sel=1` gives `stat_cnt=10` one cycle later. Without the macro, `stat_cnt=0` throughout.

Source files
------------

// File: rtl/phase_interp_sched.sv
// Round-robin scheduler sharing one phase-interpolation pipeline among NREQ requesters.
// Optional per-requester grant counters are built when PHASE_SCHED_STATS_EN is defined.
module phase_interp_sched #(
    parameter  int NREQ     = 4,
    parameter  int PHASE_DW = 15,
    parameter  int FBIT     = 8,
    parameter  int USER_DW  = 4,
    parameter  int MAX_OUT  = 4,
    localparam int IDW      = $clog2(NREQ),
    localparam int PASS_DW  = IDW + USER_DW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*PHASE_DW-1:0]  req_phase1,
    input  logic [NREQ*PHASE_DW-1:0]  req_phase2,
    input  logic [NREQ*FBIT-1:0]      req_frac,
    input  logic [NREQ*USER_DW-1:0]   req_user,
    output logic                      ip_valid,
    input  logic                      ip_ready,
    output logic [PHASE_DW-1:0]       ip_phase1,
    output logic [PHASE_DW-1:0]       ip_phase2,
    output logic [FBIT-1:0]           ip_frac,
    output logic [PASS_DW-1:0]        ip_pass_data,
    input  logic                      res_valid,
    output logic                      res_ready,
    input  logic [PHASE_DW-1:0]       res_phase,
    input  logic [PASS_DW-1:0]        res_pass_data,
    output logic [NREQ-1:0]           rsp_valid,
    input  logic [NREQ-1:0]           rsp_ready,
    output logic [PHASE_DW-1:0]       rsp_phase,
    output logic [USER_DW-1:0]        rsp_user,
    output logic [3:0]                outstanding,
    input  logic [IDW-1:0]            stat_sel,
    output logic [15:0]               stat_cnt
);

    localparam logic [3:0] MAX_OUT_W = 4'(MAX_OUT);

    logic [IDW-1:0]      last_grant_q, last_grant_d;
    logic                ip_valid_q, ip_valid_d;
    logic [PHASE_DW-1:0] phase1_q, phase1_d;
    logic [PHASE_DW-1:0] phase2_q, phase2_d;
    logic [FBIT-1:0]     frac_q, frac_d;
    logic [PASS_DW-1:0]  pass_q, pass_d;
    logic [3:0]          outstanding_q, outstanding_d;

    logic [IDW-1:0]      grant_idx;
    logic                grant_found;
    logic                can_load;
    logic                load;
    logic                ret_hs;

    // Search starts one past the previous winner, so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant_found && req_valid[(int'(last_grant_q) + k) % NREQ]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'((int'(last_grant_q) + k) % NREQ);
            end
        end
    end

    assign can_load = !rst && (!ip_valid_q || ip_ready) && (outstanding_q < MAX_OUT_W);
    assign load     = can_load && grant_found;
    assign ret_hs   = res_valid && res_ready;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign req_ready[gi] = load && (grant_idx == IDW'(gi));
    end

    always_comb begin
        ip_valid_d    = ip_valid_q;
        phase1_d      = phase1_q;
        phase2_d      = phase2_q;
        frac_d        = frac_q;
        pass_d        = pass_q;
        last_grant_d  = last_grant_q;
        outstanding_d = outstanding_q;
        if (load) begin
            ip_valid_d   = 1'b1;
            phase1_d     = req_phase1[grant_idx*PHASE_DW +: PHASE_DW];
            phase2_d     = req_phase2[grant_idx*PHASE_DW +: PHASE_DW];
            frac_d       = req_frac[grant_idx*FBIT +: FBIT];
            pass_d       = {req_user[grant_idx*USER_DW +: USER_DW], grant_idx};
            last_grant_d = grant_idx;
        end else if (ip_ready) begin
            ip_valid_d = 1'b0;
        end
        // A return against an empty counter is ignored so the count cannot wrap.
        case ({load, ret_hs && (outstanding_q != 4'd0)})
            2'b10:   outstanding_d = outstanding_q + 4'd1;
            2'b01:   outstanding_d = outstanding_q - 4'd1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ip_valid_q    <= 1'b0;
            phase1_q      <= '0;
            phase2_q      <= '0;
            frac_q        <= '0;
            pass_q        <= '0;
            last_grant_q  <= IDW'(NREQ - 1);
            outstanding_q <= '0;
        end else begin
            ip_valid_q    <= ip_valid_d;
            phase1_q      <= phase1_d;
            phase2_q      <= phase2_d;
            frac_q        <= frac_d;
            pass_q        <= pass_d;
            last_grant_q  <= last_grant_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign ip_valid     = ip_valid_q;
    assign ip_phase1    = phase1_q;
    assign ip_phase2    = phase2_q;
    assign ip_frac      = frac_q;
    assign ip_pass_data = pass_q;
    assign outstanding  = outstanding_q;

    // Return path: steer by the id carried through the interpolator; unknown ids are dropped.
    logic [IDW-1:0]  res_id;
    logic [NREQ-1:0] id_hit;
    logic [NREQ-1:0] ready_hit;

    assign res_id = res_pass_data[IDW-1:0];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ret
        assign id_hit[gi]    = (res_id == IDW'(gi));
        assign rsp_valid[gi] = res_valid && id_hit[gi];
        assign ready_hit[gi] = rsp_ready[gi] && id_hit[gi];
    end

    assign res_ready = !(|id_hit) || (|ready_hit);
    assign rsp_phase = res_phase;
    assign rsp_user  = res_pass_data[PASS_DW-1:IDW];

    ret_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(ret_hs && (outstanding_q == 4'd0)));

`ifdef PHASE_SCHED_STATS_EN
    logic [15:0] cnt_q [NREQ];
    logic [15:0] stat_q, stat_d;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else if (req_ready[i] && (cnt_q[i] != 16'hFFFF)) begin
                cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end

    always_comb begin
        stat_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (stat_sel == IDW'(i)) begin
                stat_d = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_cnt = stat_q;
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_cnt        = '0;
`endif

endmodule
